binary_add_rr_arbiter: RTL

//   Round-robin arbiter and sequencer that shares one registered WIDTH-bit adder among NUM_REQ requesters.

---
 rtl/binary_add_rr_arbiter_if.sv | 31 +++
 rtl/binary_add_rr_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/binary_add_rr_arbiter_if.sv
// binary_add_rr_arbiter_if
//   Bundles the request side (per-requester valid/ready, operands, carry-in)
//   and the response side (valid/ready, id, sum, carry-out) of the shared adder.
//   master: client/consumer view (drives requests and rsp_ready)
//   slave : arbiter view (drives req_ready and the response)
interface binary_add_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/binary_add_rr_arbiter.sv
// binary_add_rr_arbiter
//   Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     en     global enable; low blocks new grants and freezes CALC
//     bus    slave side of binary_add_rr_arbiter_if (requests + tagged result)
//     busy   high whenever the FSM is not in IDLE
//
//   state | meaning
//   IDLE  | waiting; grants the round-robin winner combinationally
//   CALC  | operands captured; adds when en=1
//   RESP  | result presented until rsp_ready handshake
module binary_add_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  binary_add_rr_arbiter_if.slave bus,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic               take;

  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_cin;
  logic [ID_W-1:0]    op_id;

  logic               rsp_valid_q, rsp_cout_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic [ID_W-1:0]    rsp_id_q;

  // First valid requester starting at rr_ptr; the ID_W-bit add wraps because
  // NUM_REQ is a power of two.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset is held
        if (en && found && rst_n) begin
          grant[win_id] = 1'b1;
          take          = 1'b1;
          state_nxt     = CALC;
        end
      end
      CALC: if (en) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_cin      <= 1'b0;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_a   <= bus.req_a[win_id*WIDTH +: WIDTH];
        op_b   <= bus.req_b[win_id*WIDTH +: WIDTH];
        op_cin <= bus.req_cin[win_id];
        op_id  <= win_id;
      end
      if (state == CALC && en) begin
        {rsp_cout_q, rsp_sum_q} <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
        rsp_id_q    <= op_id;
        rsp_valid_q <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        // last-served requester drops to lowest priority
        rr_ptr      <= rsp_id_q + ID_W'(1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule
